gray2rgb: RTL and testbench

//   Converts an 8-bit grayscale pixel stream back to RGB444 for the VGA display path.

---
 rtl/gray2rgb.sv | 68 ++++++
 tb/tb_gray2rgb.sv | 133 +++++++++++++
 2 files changed

// File: rtl/gray2rgb.sv
// gray2rgb: gray-to-RGB444 converter with frame-shadowed mode/threshold and a 2-stage pipeline
module gray2rgb #(
  parameter logic [1:0] MODE_DEFAULT   = 2'd0,
  parameter logic [7:0] THRESH_DEFAULT = 8'd128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gray_in,
  input  logic        gray_in_en,
  input  logic        frame_start,
  input  logic [1:0]  mode_in,
  input  logic [7:0]  thresh_in,
  output logic [11:0] RGB444_out,
  output logic        RGB_out_en,
  output logic [1:0]  mode_active
);
  typedef enum logic [1:0] {MONO, BINARY, HEAT, INVERT} mode_t;
  logic [1:0]  mode_q, mode_d, mode_s1_q;
  logic [7:0]  thr_q, thr_d, thr_s1_q, gray_s1_q;
  logic        en_s1_q, en_q;
  logic [11:0] rgb_q, rgb_d;
  logic [3:0]  hi, n;
  // A pixel coincident with frame_start already uses the incoming settings
  assign mode_d = frame_start ? mode_in : mode_q;
  assign thr_d  = frame_start ? thresh_in : thr_q;
  assign hi     = gray_s1_q[7:4];
  assign n      = gray_s1_q[5:2];
  always_comb begin
    rgb_d = {hi, hi, hi};
    case (mode_t'(mode_s1_q))
      BINARY: rgb_d = (gray_s1_q >= thr_s1_q) ? 12'hFFF : 12'h000;
      HEAT: case (gray_s1_q[7:6])
        2'b00:   rgb_d = {4'h0, n, 4'hF};
        2'b01:   rgb_d = {4'h0, 4'hF, 4'hF - n};
        2'b10:   rgb_d = {n, 4'hF, 4'h0};
        default: rgb_d = {4'hF, 4'hF - n, 4'h0};
      endcase
      INVERT: rgb_d = {~hi, ~hi, ~hi};
      default: rgb_d = {hi, hi, hi};
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_DEFAULT;
      thr_q     <= THRESH_DEFAULT;
      en_s1_q   <= 1'b0;
      gray_s1_q <= 8'h00;
      mode_s1_q <= 2'd0;
      thr_s1_q  <= 8'h00;
      en_q      <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      en_s1_q <= gray_in_en;
      if (gray_in_en) begin
        gray_s1_q <= gray_in;
        mode_s1_q <= mode_d;
        thr_s1_q  <= thr_d;
      end
      en_q <= en_s1_q;
      if (en_s1_q) rgb_q <= rgb_d;
    end
  end
  assign RGB444_out  = rgb_q;
  assign RGB_out_en  = en_q;
  assign mode_active = mode_q;
endmodule

// File: tb/tb_gray2rgb.sv
// tb_gray2rgb: directed scoreboard bench for gray2rgb
module tb_gray2rgb;
  logic        clk = 1'b0, rst_n = 1'b0, gray_in_en = 1'b0, frame_start = 1'b0;
  logic [7:0]  gray_in = 8'h00, thresh_in = 8'd128;
  logic [1:0]  mode_in = 2'd0;
  logic [11:0] RGB444_out;
  logic        RGB_out_en;
  logic [1:0]  mode_active;
  logic [11:0] exp_q[$];
  int          n_cmp = 0, n_err = 0;

  gray2rgb dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_in_en(gray_in_en),
    .frame_start(frame_start), .mode_in(mode_in), .thresh_in(thresh_in),
    .RGB444_out(RGB444_out), .RGB_out_en(RGB_out_en), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are applied, sampled on the next posedge, then released #1 later
  task automatic drive(input logic en, input logic [7:0] g, input logic fs, input logic [11:0] exp);
    gray_in_en  = en;
    gray_in     = g;
    frame_start = fs;
    if (en) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    gray_in_en  = 1'b0;
    frame_start = 1'b0;
  endtask

  always @(negedge clk)
    if (rst_n && RGB_out_en) begin
      if (exp_q.size() == 0) check("unexpected_output", RGB444_out, 12'hxxx);
      else check("scoreboard", RGB444_out, exp_q.pop_front());
    end

  initial begin
    #12;
    check("reset_rgb", RGB444_out, 12'h000);
    check("reset_en", {11'd0, RGB_out_en}, 12'h000);
    check("reset_mode", {10'd0, mode_active}, 12'h000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // 1: MONO default, latency exactly 2 clk
    drive(1'b1, 8'hA5, 1'b0, 12'hAAA);
    check("lat_t1", {11'd0, RGB_out_en}, 12'h000);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    check("lat_t2_en", {11'd0, RGB_out_en}, 12'h001);
    check("lat_t2_rgb", RGB444_out, 12'hAAA);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    check("lat_t3_en", {11'd0, RGB_out_en}, 12'h000);
    // 2: BINARY, frame_start with no pixel, threshold equality counts
    mode_in = 2'd1; thresh_in = 8'd128;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    check("mode_bin", {10'd0, mode_active}, 12'h001);
    drive(1'b1, 8'd127, 1'b0, 12'h000);
    drive(1'b1, 8'd128, 1'b0, 12'hFFF);
    drive(1'b1, 8'd255, 1'b0, 12'hFFF);
    thresh_in = 8'd0;
    drive(1'b1, 8'd100, 1'b0, 12'h000);
    // back-to-back frame_start: last wins
    mode_in = 2'd3;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    mode_in = 2'd2;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    check("mode_b2b", {10'd0, mode_active}, 12'h002);
    // 3: HEAT
    drive(1'b1, 8'h00, 1'b0, 12'h00F);
    drive(1'b1, 8'h40, 1'b0, 12'h0FF);
    drive(1'b1, 8'h7F, 1'b0, 12'h0F0);
    drive(1'b1, 8'h80, 1'b0, 12'h0F0);
    drive(1'b1, 8'hC0, 1'b0, 12'hFF0);
    drive(1'b1, 8'hFF, 1'b0, 12'hF00);
    drive(1'b1, 8'h9C, 1'b0, 12'h7F0);
    // 4: mode change without frame_start is ignored; coincident pixel takes new mode
    mode_in = 2'd0;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    mode_in = 2'd3;
    drive(1'b1, 8'h30, 1'b0, 12'h333);
    drive(1'b1, 8'h30, 1'b1, 12'hCCC);
    check("mode_inv", {10'd0, mode_active}, 12'h003);
    drive(1'b1, 8'hF0, 1'b0, 12'h000);
    // 5: gap passes through, output holds
    mode_in = 2'd0;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    drive(1'b1, 8'h10, 1'b0, 12'h111);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    check("gap_first", RGB444_out, 12'h111);
    drive(1'b1, 8'h20, 1'b0, 12'h222);
    check("gap_en", {11'd0, RGB_out_en}, 12'h000);
    check("gap_hold", RGB444_out, 12'h111);
    drive(1'b1, 8'h30, 1'b0, 12'h333);
    check("gap_after", RGB444_out, 12'h222);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    check("gap_last", RGB444_out, 12'h333);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    // 6: async reset with pixels in flight
    mode_in = 2'd3;
    drive(1'b0, 8'h00, 1'b1, 12'h000);
    drive(1'b1, 8'h50, 1'b0, 12'hAAA);
    gray_in_en = 1'b1; gray_in = 8'h60;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_rgb", RGB444_out, 12'h000);
    check("arst_en", {11'd0, RGB_out_en}, 12'h000);
    check("arst_mode", {10'd0, mode_active}, 12'h000);
    gray_in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_stale", {11'd0, RGB_out_en}, 12'h000);
    end
    drive(1'b1, 8'h70, 1'b0, 12'h777);
    check("post_rst_t1", {11'd0, RGB_out_en}, 12'h000);
    drive(1'b0, 8'h00, 1'b0, 12'h000);
    check("post_rst_t2", RGB444_out, 12'h777);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 12'(exp_q.size()), 12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
